// File: rtl/dma_bus_master_if.sv
// dma_bus_master_if
//   Signal bundle between the SDMAC DMA bus initiator and its surroundings
//   (DMA FIFO/control on one side, the 68030-style system bus on the other).
//
//   Request side : REQ, REQ_RW, REQ_ADDR, WDATA  -> initiator
//                  ACK, ERR, RDATA               <- initiator
//   Bus side     : BR_, BGACK_, OWN, AS_, DS_, RW, SIZ, ADDR_OUT,
//                  DATA_OUT, DATA_OE             <- initiator
//                  BG_, BGACK_IN_, BUS_AS_, DATA_IN, DSACK_, BERR_ -> initiator
//   Debug        : dbg_state (current FSM state encoding) <- initiator
//
// Request handshake: the requester raises REQ with REQ_RW/REQ_ADDR/WDATA
// stable and holds them until exactly one of ACK or ERR pulses for one cycle;
// the transfer is complete on that pulse and RDATA (reads) is valid then.
// Dropping REQ early does not cancel a cycle already on the bus.
interface dma_bus_master_if;
  logic        REQ;
  logic        REQ_RW;
  logic [31:0] REQ_ADDR;
  logic [31:0] WDATA;
  logic        ACK;
  logic        ERR;
  logic [31:0] RDATA;

  logic        BR_;
  logic        BG_;
  logic        BGACK_IN_;
  logic        BUS_AS_;
  logic        BGACK_;
  logic        OWN;
  logic        AS_;
  logic        DS_;
  logic        RW;
  logic [1:0]  SIZ;
  logic [31:0] ADDR_OUT;
  logic [31:0] DATA_OUT;
  logic        DATA_OE;
  logic [31:0] DATA_IN;
  logic [1:0]  DSACK_;
  logic        BERR_;

  logic [3:0]  dbg_state;

  modport master (
    input  REQ, REQ_RW, REQ_ADDR, WDATA,
    output ACK, ERR, RDATA,
    output BR_, BGACK_, OWN, AS_, DS_, RW, SIZ, ADDR_OUT, DATA_OUT, DATA_OE,
    input  BG_, BGACK_IN_, BUS_AS_, DATA_IN, DSACK_, BERR_,
    output dbg_state
  );

  modport slave (
    output REQ, REQ_RW, REQ_ADDR, WDATA,
    input  ACK, ERR, RDATA,
    input  BR_, BGACK_, OWN, AS_, DS_, RW, SIZ, ADDR_OUT, DATA_OUT, DATA_OE,
    output BG_, BGACK_IN_, BUS_AS_, DATA_IN, DSACK_, BERR_,
    input  dbg_state
  );
endinterface

// File: rtl/dma_bus_master.sv
// dma_bus_master
//   68030-style bus initiator for the SDMAC DMA engine. Arbitrates with
//   BR_/BG_/BGACK_, runs long-word read/write cycles with AS_/DS_/RW,
//   terminates on DSACK_, BERR_ or a wait-state timeout, and keeps bus
//   ownership for HOLD_CYCLES idle cycles so back-to-back requests skip
//   arbitration.
//
//   Ports:
//     SCLK  - system clock, rising edge
//     RST_  - synchronous reset, active low
//     bus   - dma_bus_master_if.master (request side, bus side, dbg_state)
//
//   All bus strobes and enables are registered: the value for the next
//   state is computed combinationally and loaded on the transition edge,
//   so each output is glitch-free and valid for the whole state.
module dma_bus_master #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input logic              SCLK,
  input logic              RST_,
  dma_bus_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    REQ_BUS = 4'd1,
    GRANT   = 4'd2,
    S_ADDR  = 4'd3,
    S_STRB  = 4'd4,
    S_WAIT  = 4'd5,
    S_END   = 4'd6,
    HOLD    = 4'd7,
    RELEASE = 4'd8
  } state_t;

  localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  state_t state, state_next;

  // Two-flop synchronisers, reset to the negated (high) level.
  logic [1:0] bg_r, bgack_in_r, bus_as_r, berr_r;
  logic [1:0] dsack_r1, dsack_r2;
  logic       bg_s, bgack_in_s, bus_as_s, berr_s;
  logic [1:0] dsack_s;

  logic [7:0]    tmo_cnt;
  logic [HW-1:0] hold_cnt;

  logic          rw_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          br_q, bgack_q, own_q, as_q, ds_q, rw_out_q, oe_q, ack_q, err_q;

  logic term_ok, term_err;
  logic rw_eff, owned, in_cycle;
  logic br_d, bgack_d, own_d, as_d, ds_d, rw_out_d, oe_d;

  always_ff @(posedge SCLK) begin
    if (!RST_) begin
      bg_r       <= 2'b11;
      bgack_in_r <= 2'b11;
      bus_as_r   <= 2'b11;
      berr_r     <= 2'b11;
      dsack_r1   <= 2'b11;
      dsack_r2   <= 2'b11;
    end else begin
      bg_r       <= {bg_r[0], bus.BG_};
      bgack_in_r <= {bgack_in_r[0], bus.BGACK_IN_};
      bus_as_r   <= {bus_as_r[0], bus.BUS_AS_};
      berr_r     <= {berr_r[0], bus.BERR_};
      dsack_r1   <= bus.DSACK_;
      dsack_r2   <= dsack_r1;
    end
  end

  assign bg_s       = bg_r[1];
  assign bgack_in_s = bgack_in_r[1];
  assign bus_as_s   = bus_as_r[1];
  assign berr_s     = berr_r[1];
  assign dsack_s    = dsack_r2;

  // Next-state and next-output decode.
  always_comb begin
    state_next = state;
    term_ok    = 1'b0;
    term_err   = 1'b0;
    case (state)
      IDLE:    if (bus.REQ) state_next = REQ_BUS;
      // Take the bus only once it is granted and no other master or cycle
      // is still active on it.
      REQ_BUS: if (!bg_s && bus_as_s && bgack_in_s) state_next = GRANT;
      GRANT:   state_next = S_ADDR;
      S_ADDR:  state_next = S_STRB;
      S_STRB:  state_next = S_WAIT;
      S_WAIT: begin
        // Bus error wins over a simultaneous DSACK.
        if (!berr_s) begin
          state_next = S_END;
          term_err   = 1'b1;
        end else if (dsack_s != 2'b11) begin
          state_next = S_END;
          term_ok    = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_END;
          term_err   = 1'b1;
        end
      end
      // A new cycle may only start once the previous slave has negated its
      // termination signals, otherwise a stale DSACK would end it at once.
      S_END: begin
        if (bus.REQ && dsack_s == 2'b11 && berr_s) state_next = S_ADDR;
        else                                        state_next = HOLD;
      end
      HOLD: begin
        if (bus.REQ) begin
          if (dsack_s == 2'b11 && berr_s) state_next = S_ADDR;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Direction for the coming state: freshly sampled when a cycle starts.
    rw_eff   = (state_next == S_ADDR) ? bus.REQ_RW : rw_q;
    owned    = state_next inside {GRANT, S_ADDR, S_STRB, S_WAIT, S_END, HOLD};
    in_cycle = state_next inside {S_ADDR, S_STRB, S_WAIT, S_END};

    br_d     = (state_next != REQ_BUS);
    bgack_d  = !owned;
    own_d    = owned;
    as_d     = !(state_next inside {S_STRB, S_WAIT});
    // Reads assert DS_ with AS_; writes one cycle later so data has settled.
    ds_d     = !((state_next == S_STRB && rw_eff) || state_next == S_WAIT);
    rw_out_d = in_cycle ? rw_eff : 1'b1;
    oe_d     = in_cycle && !rw_eff;
  end

  always_ff @(posedge SCLK) begin
    if (!RST_) begin
      state    <= IDLE;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      br_q     <= 1'b1;
      bgack_q  <= 1'b1;
      own_q    <= 1'b0;
      as_q     <= 1'b1;
      ds_q     <= 1'b1;
      rw_out_q <= 1'b1;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_ADDR) begin
        rw_q    <= bus.REQ_RW;
        addr_q  <= bus.REQ_ADDR & ADDR_MASK;
        wdata_q <= bus.WDATA;
      end
      if (term_ok && rw_q) rdata_q <= bus.DATA_IN;
      br_q     <= br_d;
      bgack_q  <= bgack_d;
      own_q    <= own_d;
      as_q     <= as_d;
      ds_q     <= ds_d;
      rw_out_q <= rw_out_d;
      oe_q     <= oe_d;
      ack_q    <= term_ok;
      err_q    <= term_err;
      tmo_cnt  <= (state == S_WAIT) ? tmo_cnt + 8'd1 : 8'd0;
      // Idle hold time only accumulates while no request is pending.
      if (state == HOLD && state_next == HOLD)
        hold_cnt <= bus.REQ ? hold_cnt : hold_cnt + HW'(1);
      else
        hold_cnt <= '0;
    end
  end

  assign bus.ACK       = ack_q;
  assign bus.ERR       = err_q;
  assign bus.RDATA     = rdata_q;
  assign bus.BR_       = br_q;
  assign bus.BGACK_    = bgack_q;
  assign bus.OWN       = own_q;
  assign bus.AS_       = as_q;
  assign bus.DS_       = ds_q;
  assign bus.RW        = rw_out_q;
  assign bus.SIZ       = 2'b00;
  assign bus.ADDR_OUT  = addr_q;
  assign bus.DATA_OUT  = wdata_q;
  assign bus.DATA_OE   = oe_q;
  assign bus.dbg_state = state;

endmodule
